// File: rtl/stream_sel_lock.sv
// stream_sel_lock
//
// Purpose:
//   Registered routing stage that sits directly in front of stream_demux.
//   The output select is captured on the first beat of each burst. It is
//   then held until the burst's last beat has been accepted, so every beat
//   of a burst leaves through the same demux port. Data, last and select
//   pass through one register stage at full throughput, with no bubble
//   between beats.
//
// Parameters:
//   N_OUP       number of downstream demux outputs
//   LOG_N_OUP   select width (derived, do not override)
//   DATA_WIDTH  payload width in bits
//   MAX_BEATS   maximum burst length in beats (>= 1)
//   CNT_WIDTH   beat counter width (derived, do not override)
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   inp_valid_i  in   input beat valid
//   inp_ready_o  out  input beat ready (combinational)
//   inp_data_i   in   input payload
//   inp_sel_i    in   requested output, sampled on the first beat of a burst
//   inp_last_i   in   final beat of a burst
//   oup_valid_o  out  output beat valid
//   oup_ready_i  in   output ready
//   oup_data_o   out  registered payload
//   oup_last_o   out  registered last
//   oup_sel_o    out  locked select
//   busy_o       out  high while a burst is in progress
//   beat_cnt_o   out  beats accepted so far in the current burst (saturating)
//
// Configuration macro:
//   STREAM_SEL_LOCK_MAXLEN_EN  when defined, the MAX_BEATS-th beat of a
//                              burst is forced to be its last beat. When
//                              undefined, burst length is unlimited.

module stream_sel_lock #(
  parameter int unsigned N_OUP      = 32'd4,
  parameter int unsigned LOG_N_OUP  = (N_OUP > 1) ? $clog2(N_OUP) : 1,
  parameter int unsigned DATA_WIDTH = 32'd32,
  parameter int unsigned MAX_BEATS  = 32'd16,
  parameter int unsigned CNT_WIDTH  = $clog2(MAX_BEATS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  inp_valid_i,
  output logic                  inp_ready_o,
  input  logic [DATA_WIDTH-1:0] inp_data_i,
  input  logic [LOG_N_OUP-1:0]  inp_sel_i,
  input  logic                  inp_last_i,
  output logic                  oup_valid_o,
  input  logic                  oup_ready_i,
  output logic [DATA_WIDTH-1:0] oup_data_o,
  output logic                  oup_last_o,
  output logic [LOG_N_OUP-1:0]  oup_sel_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  beat_cnt_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                  state_q, state_n;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    last_q;
  logic [LOG_N_OUP-1:0]    sel_q, sel_n;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_n;

  logic                    in_hs;
  logic                    force_last;
  logic                    eff_last;
  logic [CNT_WIDTH-1:0]    cnt_inc;

  // The register can take a new beat when it is empty or being drained
  // in this same cycle, which gives full throughput without a bubble.
  assign inp_ready_o = !valid_q || oup_ready_i;
  assign in_hs       = inp_valid_i && inp_ready_o;

  // In IDLE the counter is 0, so with MAX_BEATS=1 every beat is forced last.
`ifdef STREAM_SEL_LOCK_MAXLEN_EN
  assign force_last = (cnt_q == CNT_WIDTH'(MAX_BEATS - 1));
`else
  assign force_last = 1'b0;
`endif

  assign eff_last = inp_last_i || force_last;

  // The counter sticks at its all-ones value instead of wrapping.
  assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // Burst tracking. The select is only captured on a header beat in IDLE;
  // since that beat is only accepted when the register is empty or draining,
  // oup_sel_o never changes underneath a valid beat.
  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    cnt_n   = cnt_q;
    if (in_hs) begin
      unique case (state_q)
        IDLE: begin
          sel_n = inp_sel_i;
          if (eff_last) begin
            cnt_n = '0;
          end else begin
            state_n = BURST;
            cnt_n   = CNT_WIDTH'(1);
          end
        end
        BURST: begin
          if (eff_last) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // State, counter and select registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      cnt_q   <= cnt_n;
    end
  end

  // Payload register: a new beat replaces the old one, even on a
  // simultaneous drain. Otherwise a drain simply empties the slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_hs) begin
      valid_q <= 1'b1;
      data_q  <= inp_data_i;
      last_q  <= eff_last;
    end else if (oup_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign oup_valid_o = valid_q;
  assign oup_data_o  = data_q;
  assign oup_last_o  = last_q;
  assign oup_sel_o   = sel_q;
  assign busy_o      = (state_q == BURST);
  assign beat_cnt_o  = cnt_q;

endmodule

// File: tb/tb_stream_sel_lock.sv
// tb_stream_sel_lock
//
// Purpose:
//   Self-checking bench for stream_sel_lock with MAX_BEATS=4. A transaction
//   level reference model tracks the buffered beat, the burst position as a
//   plain integer and the locked select. It also honours
//   STREAM_SEL_LOCK_MAXLEN_EN, so the same bench works for either build.

module tb_stream_sel_lock;

  localparam int DW   = 32;
  localparam int SW   = 2;
  localparam int MAXB = 4;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          inp_valid;
  logic          inp_ready;
  logic [DW-1:0] inp_data;
  logic [SW-1:0] inp_sel;
  logic          inp_last;
  logic          oup_valid;
  logic          oup_ready;
  logic [DW-1:0] oup_data;
  logic          oup_last;
  logic [SW-1:0] oup_sel;
  logic          busy;
  logic [CW-1:0] beat_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic          exp_last;
  logic [SW-1:0] exp_sel;
  int            beats;
  logic [SW-1:0] locked;
  logic          seen_ready;
  logic          want_ready;

  stream_sel_lock #(
    .N_OUP      (4),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAXB)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .inp_valid_i (inp_valid),
    .inp_ready_o (inp_ready),
    .inp_data_i  (inp_data),
    .inp_sel_i   (inp_sel),
    .inp_last_i  (inp_last),
    .oup_valid_o (oup_valid),
    .oup_ready_i (oup_ready),
    .oup_data_o  (oup_data),
    .oup_last_o  (oup_last),
    .oup_sel_o   (oup_sel),
    .busy_o      (busy),
    .beat_cnt_o  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] exp_cnt();
    return (beats > CMAX) ? CW'(CMAX) : CW'(beats);
  endfunction

  function automatic logic exp_busy();
    return beats != 0;
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_last  = 1'b0;
    exp_sel   = '0;
    beats     = 0;
    locked    = '0;
  endtask

  // Drive one cycle starting just after a rising edge, sample the ready
  // before the edge, then advance the model at the edge.
  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic l, input logic r);
    logic acc, drain, eff;
    inp_valid = v;
    inp_data  = d;
    inp_sel   = s;
    inp_last  = l;
    oup_ready = r;
    #2;
    seen_ready = inp_ready;
    want_ready = !exp_valid || r;
    acc   = v && want_ready;
    drain = exp_valid && r;
    @(posedge clk);
    if (acc) begin
      if (beats == 0) locked = s;
      beats = beats + 1;
      eff = l;
`ifdef STREAM_SEL_LOCK_MAXLEN_EN
      if (beats == MAXB) eff = 1'b1;
`endif
      exp_valid = 1'b1;
      exp_data  = d;
      exp_last  = eff;
      exp_sel   = locked;
      if (eff) beats = 0;
    end else if (drain) begin
      exp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    inp_valid = 0; inp_data = '0; inp_sel = '0; inp_last = 0; oup_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", oup_valid); end
    checks++; if (oup_data !== '0) begin errors++; $display("[TB] FAIL reset_data got=%h want=0", oup_data); end
    checks++; if (oup_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got=%b want=0", oup_last); end
    checks++; if (oup_sel !== '0) begin errors++; $display("[TB] FAIL reset_sel got=%0d want=0", oup_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (beat_cnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt got=%0d want=0", beat_cnt); end
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Start a burst and leave a beat buffered, then reset asynchronously.
    step(1, 32'hAAAA0001, 2'd2, 0, 0);
    step(0, 32'h0, 2'd0, 0, 0);
    checks++; if (oup_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset valid=%b busy=%b want=1,1", oup_valid, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid got=%b want=0", oup_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_busy got=%b want=0", busy); end
    checks++; if (beat_cnt !== '0) begin errors++; $display("[TB] FAIL async_cnt got=%0d want=0", beat_cnt); end
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // First beat after reset is a header: its select is captured.
    step(1, 32'hBBBB0001, 2'd3, 0, 1);
    checks++; if (oup_sel !== exp_sel || beat_cnt !== exp_cnt()) begin errors++; $display("[TB] FAIL post_reset_hdr sel=%0d cnt=%0d want=%0d,%0d", oup_sel, beat_cnt, exp_sel, exp_cnt()); end
    step(1, 32'hBBBB0002, 2'd0, 1, 1);
    step(0, 32'h0, 2'd0, 0, 1);
  endtask

  task automatic test_burst_lock();
    logic [SW-1:0] sels [3];
    logic [CW-1:0] cnts [3];
    sels[0] = 2'd2; sels[1] = 2'd1; sels[2] = 2'd3;
    cnts[0] = CW'(1); cnts[1] = CW'(2); cnts[2] = CW'(0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'hC0DE0000 + i, sels[i], (i == 2), 1);
      checks++; if (oup_valid !== 1'b1 || oup_sel !== 2'd2 || oup_data !== exp_data) begin errors++; $display("[TB] FAIL lock_beat%0d valid=%b sel=%0d data=%h want=1,2,%h", i, oup_valid, oup_sel, oup_data, exp_data); end
      checks++; if (beat_cnt !== cnts[i] || busy !== (i != 2)) begin errors++; $display("[TB] FAIL lock_cnt%0d cnt=%0d busy=%b want=%0d,%b", i, beat_cnt, busy, cnts[i], (i != 2)); end
    end
    checks++; if (oup_last !== 1'b1) begin errors++; $display("[TB] FAIL lock_last got=%b want=1", oup_last); end
    step(0, 32'h0, 2'd0, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] s_tab [4];
    logic          l_tab [4];
    s_tab[0] = 2'd1; s_tab[1] = 2'd0; s_tab[2] = 2'd3; s_tab[3] = 2'd2;
    l_tab[0] = 0;    l_tab[1] = 1;    l_tab[2] = 0;    l_tab[3] = 1;
    for (int i = 0; i < 4; i++) begin
      step(1, 32'hB2B00000 + i, s_tab[i], l_tab[i], 1);
      checks++; if (seen_ready !== 1'b1 || oup_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_bubble%0d ready=%b valid=%b want=1,1", i, seen_ready, oup_valid); end
      checks++; if (oup_sel !== ((i < 2) ? 2'd1 : 2'd3) || oup_data !== exp_data) begin errors++; $display("[TB] FAIL b2b_sel%0d sel=%0d data=%h want=%0d,%h", i, oup_sel, oup_data, ((i < 2) ? 1 : 3), exp_data); end
    end
    step(0, 32'h0, 2'd0, 0, 1);
  endtask

  task automatic test_backpressure();
    step(1, 32'hDEAD0001, 2'd1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'hDEAD0100 + i, 2'd2, 0, 0);
      checks++; if (seen_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready%0d got=%b want=0", i, seen_ready); end
      checks++; if (oup_data !== 32'hDEAD0001 || oup_last !== 1'b0 || oup_sel !== 2'd1 || oup_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold%0d data=%h last=%b sel=%0d valid=%b want=dead0001,0,1,1", i, oup_data, oup_last, oup_sel, oup_valid); end
    end
    // Release: the waiting beat replaces the drained one, then the burst ends.
    step(1, 32'hDEAD0002, 2'd3, 1, 1);
    checks++; if (oup_data !== exp_data || oup_sel !== exp_sel || oup_last !== exp_last || beat_cnt !== exp_cnt()) begin errors++; $display("[TB] FAIL bp_release data=%h sel=%0d last=%b cnt=%0d want=%h,%0d,%b,%0d", oup_data, oup_sel, oup_last, beat_cnt, exp_data, exp_sel, exp_last, exp_cnt()); end
    step(0, 32'h0, 2'd0, 0, 1);
    checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got=%b want=0", oup_valid); end
  endtask

  task automatic test_single_beat();
    step(1, 32'h51A61E00, 2'd3, 1, 1);
    step(1, 32'h51A61E01, 2'd0, 1, 1);
    checks++; if (oup_sel !== 2'd0 || oup_last !== 1'b1 || busy !== 1'b0 || beat_cnt !== '0) begin errors++; $display("[TB] FAIL single sel=%0d last=%b busy=%b cnt=%0d want=0,1,0,0", oup_sel, oup_last, busy, beat_cnt); end
    step(0, 32'h0, 2'd0, 0, 1);
  endtask

  task automatic test_maxlen();
    logic [SW-1:0] s;
    for (int i = 1; i <= 6; i++) begin
      s = SW'($urandom_range(0, 3));
      step(1, 32'h3A000000 + i, s, (i == 6), 1);
      checks++; if (oup_last !== exp_last || oup_sel !== exp_sel) begin errors++; $display("[TB] FAIL maxlen_beat%0d last=%b sel=%0d want=%b,%0d", i, oup_last, oup_sel, exp_last, exp_sel); end
      checks++; if (busy !== exp_busy() || beat_cnt !== exp_cnt()) begin errors++; $display("[TB] FAIL maxlen_state%0d busy=%b cnt=%0d want=%b,%0d", i, busy, beat_cnt, exp_busy(), exp_cnt()); end
    end
    step(0, 32'h0, 2'd0, 0, 1);
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= CMAX + 3; i++) begin
      step(1, 32'h5A700000 + i, SW'(i), (i == CMAX + 3), 1);
      checks++; if (beat_cnt !== exp_cnt() || busy !== exp_busy() || oup_sel !== exp_sel) begin errors++; $display("[TB] FAIL sat_beat%0d cnt=%0d busy=%b sel=%0d want=%0d,%b,%0d", i, beat_cnt, busy, oup_sel, exp_cnt(), exp_busy(), exp_sel); end
    end
    step(0, 32'h0, 2'd0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom, SW'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
      checks++; if (seen_ready !== want_ready) begin errors++; $display("[TB] FAIL rnd_ready%0d got=%b want=%b", i, seen_ready, want_ready); end
      checks++; if (oup_valid !== exp_valid || oup_data !== exp_data || oup_last !== exp_last || oup_sel !== exp_sel) begin errors++; $display("[TB] FAIL rnd_beat%0d valid=%b data=%h last=%b sel=%0d want=%b,%h,%b,%0d", i, oup_valid, oup_data, oup_last, oup_sel, exp_valid, exp_data, exp_last, exp_sel); end
      checks++; if (busy !== exp_busy() || beat_cnt !== exp_cnt()) begin errors++; $display("[TB] FAIL rnd_state%0d busy=%b cnt=%0d want=%b,%0d", i, busy, beat_cnt, exp_busy(), exp_cnt()); end
    end
  endtask

  initial begin
    test_reset();
    test_burst_lock();
    test_back_to_back();
    test_backpressure();
    test_single_beat();
    test_maxlen();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
